// File: rtl/dut_vector_sequencer.sv
// Vector sequencer for a combinational block: drives stored stimuli, waits a settle time,
// captures and compares each result, and reports error count and first failing index.
module dut_vector_sequencer #(
    parameter int IN_W   = 20,
    parameter int OUT_W  = 10,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int SETTLE = 1,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [IN_W-1:0]   load_stim,
    input  logic [OUT_W-1:0]  load_exp,
    input  logic [ADDR_W:0]   run_len,
    input  logic              start,
    output logic [IN_W-1:0]   dut_in,
    input  logic [OUT_W-1:0]  dut_out,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [CNT_W-1:0]  err_count,
    output logic              first_fail_valid,
    output logic [ADDR_W-1:0] first_fail_idx,
    output logic              res_valid,
    output logic [ADDR_W-1:0] res_idx,
    output logic [OUT_W-1:0]  res_data
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_APPLY   = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SET_W-1:0]  SET_LAST  = SET_W'((SETTLE > 0) ? (SETTLE - 1) : 0);
    localparam logic [SET_W-1:0]  SET_ZERO  = {SET_W{1'b0}};
    localparam logic [SET_W-1:0]  SET_ONE   = SET_W'(1'b1);
    localparam logic [ADDR_W:0]   LEN_MAX   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   LEN_ZERO  = {(ADDR_W + 1){1'b0}};
    localparam logic [ADDR_W:0]   LEN_ONE   = (ADDR_W + 1)'(1'b1);
    localparam logic [ADDR_W-1:0] IDX_ZERO  = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] IDX_ONE   = ADDR_W'(1'b1);
    localparam logic [CNT_W-1:0]  CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    state_t              state_r, state_s;
    logic [ADDR_W-1:0]   idx_r, idx_s;
    logic [ADDR_W:0]     len_r, len_s;
    logic [SET_W-1:0]    cnt_r, cnt_s;
    logic [IN_W-1:0]     dut_in_r, dut_in_s;
    logic                busy_r, busy_s;
    logic                done_r, done_s;
    logic                pass_r, pass_s;
    logic [CNT_W-1:0]    err_r, err_s;
    logic                ffv_r, ffv_s;
    logic [ADDR_W-1:0]   ffi_r, ffi_s;
    logic                res_valid_r, res_valid_s;
    logic [ADDR_W-1:0]   res_idx_r, res_idx_s;
    logic [OUT_W-1:0]    res_data_r, res_data_s;

    // Table is deliberately outside the reset domain so vectors survive rst.
    logic [IN_W+OUT_W-1:0] mem_r [DEPTH];
    logic [IN_W-1:0]       stim_s;
    logic [OUT_W-1:0]      exp_s;
    logic                  idle_s;

    assign stim_s = mem_r[idx_r][IN_W+OUT_W-1:OUT_W];
    assign exp_s  = mem_r[idx_r][OUT_W-1:0];
    assign idle_s = (state_r == ST_IDLE) || (state_r == ST_DONE);

    // Table write port, honoured only when no run is in progress.
    always_ff @(posedge clk) begin
        if (load_en && idle_s) begin
            mem_r[load_addr] <= {load_stim, load_exp};
        end
    end

    // Next-state and next-output logic for the sequencer.
    always_comb begin
        state_s     = state_r;
        idx_s       = idx_r;
        len_s       = len_r;
        cnt_s       = cnt_r;
        dut_in_s    = dut_in_r;
        busy_s      = busy_r;
        done_s      = done_r;
        pass_s      = pass_r;
        err_s       = err_r;
        ffv_s       = ffv_r;
        ffi_s       = ffi_r;
        res_valid_s = 1'b0;
        res_idx_s   = res_idx_r;
        res_data_s  = res_data_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start && !load_en) begin
                    idx_s = IDX_ZERO;
                    cnt_s = SET_ZERO;
                    err_s = CNT_ZERO;
                    ffv_s = 1'b0;
                    ffi_s = IDX_ZERO;
                    if (run_len == LEN_ZERO) begin
                        len_s   = LEN_ZERO;
                        state_s = ST_DONE;
                        busy_s  = 1'b0;
                        done_s  = 1'b1;
                        pass_s  = 1'b1;
                    end else begin
                        len_s   = (run_len > LEN_MAX) ? LEN_MAX : run_len;
                        state_s = ST_APPLY;
                        busy_s  = 1'b1;
                        done_s  = 1'b0;
                        pass_s  = 1'b0;
                    end
                end else begin
                    state_s = state_r;
                end
            end
            ST_APPLY: begin
                dut_in_s = stim_s;
                cnt_s    = SET_ZERO;
                if (SETTLE > 0) begin
                    state_s = ST_SETTLE;
                end else begin
                    state_s = ST_CAPTURE;
                end
            end
            ST_SETTLE: begin
                if (cnt_r == SET_LAST) begin
                    state_s = ST_CAPTURE;
                end else begin
                    cnt_s = cnt_r + SET_ONE;
                end
            end
            ST_CAPTURE: begin
                res_valid_s = 1'b1;
                res_idx_s   = idx_r;
                res_data_s  = dut_out;
                if (dut_out != exp_s) begin
                    err_s = (err_r == CNT_MAX) ? err_r : (err_r + CNT_ONE);
                    if (!ffv_r) begin
                        ffv_s = 1'b1;
                        ffi_s = idx_r;
                    end else begin
                        ffi_s = ffi_r;
                    end
                end else begin
                    err_s = err_r;
                end
                if ({1'b0, idx_r} == (len_r - LEN_ONE)) begin
                    state_s = ST_DONE;
                    busy_s  = 1'b0;
                    done_s  = 1'b1;
                    pass_s  = (err_s == CNT_ZERO);
                end else begin
                    idx_s   = idx_r + IDX_ONE;
                    state_s = ST_APPLY;
                end
            end
            default: begin
                state_s = ST_IDLE;
                busy_s  = 1'b0;
            end
        endcase
    end

    // State and output registers; rst aborts any run without emitting a result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            idx_r       <= IDX_ZERO;
            len_r       <= LEN_ZERO;
            cnt_r       <= SET_ZERO;
            dut_in_r    <= {IN_W{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            pass_r      <= 1'b0;
            err_r       <= CNT_ZERO;
            ffv_r       <= 1'b0;
            ffi_r       <= IDX_ZERO;
            res_valid_r <= 1'b0;
            res_idx_r   <= IDX_ZERO;
            res_data_r  <= {OUT_W{1'b0}};
        end else begin
            state_r     <= state_s;
            idx_r       <= idx_s;
            len_r       <= len_s;
            cnt_r       <= cnt_s;
            dut_in_r    <= dut_in_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
            pass_r      <= pass_s;
            err_r       <= err_s;
            ffv_r       <= ffv_s;
            ffi_r       <= ffi_s;
            res_valid_r <= res_valid_s;
            res_idx_r   <= res_idx_s;
            res_data_r  <= res_data_s;
        end
    end

    assign dut_in           = dut_in_r;
    assign busy             = busy_r;
    assign done             = done_r;
    assign pass             = pass_r;
    assign err_count        = err_r;
    assign first_fail_valid = ffv_r;
    assign first_fail_idx   = ffi_r;
    assign res_valid        = res_valid_r;
    assign res_idx          = res_idx_r;
    assign res_data         = res_data_r;

endmodule

// File: tb/tb_dut_vector_sequencer.sv
// Directed bench for dut_vector_sequencer with a stand-in combinational block:
// out = 10'h210 | (in[19] ? 8 : 0) | (in[5] ? 4 : 0).
module tb_dut_vector_sequencer;

    logic        clk;
    logic        rst;
    logic        load_en;
    logic [3:0]  load_addr;
    logic [19:0] load_stim;
    logic [9:0]  load_exp;
    logic [4:0]  run_len;
    logic        start;

    logic [19:0] dut_in;
    logic [9:0]  dut_out;
    logic        busy, done, pass, first_fail_valid, res_valid;
    logic [7:0]  err_count;
    logic [3:0]  first_fail_idx, res_idx;
    logic [9:0]  res_data;

    logic [19:0] s_dut_in;
    logic [9:0]  s_dut_out;
    logic        s_busy, s_done, s_pass, s_ffv, s_res_valid;
    logic [1:0]  s_err_count;
    logic [3:0]  s_ffi, s_res_idx;
    logic [9:0]  s_res_data;

    int compared;
    int mismatched;
    int nres;
    int done_k;
    logic [3:0] got_idx  [32];
    logic [9:0] got_data [32];

    function automatic logic [9:0] dut_model(input logic [19:0] x);
        return 10'h210 | (x[19] ? 10'h008 : 10'h000) | (x[5] ? 10'h004 : 10'h000);
    endfunction

    assign dut_out   = dut_model(dut_in);
    assign s_dut_out = dut_model(s_dut_in);

    dut_vector_sequencer #(.SETTLE(1), .CNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr),
        .load_stim(load_stim), .load_exp(load_exp), .run_len(run_len), .start(start),
        .dut_in(dut_in), .dut_out(dut_out), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .first_fail_valid(first_fail_valid),
        .first_fail_idx(first_fail_idx), .res_valid(res_valid), .res_idx(res_idx),
        .res_data(res_data)
    );

    dut_vector_sequencer #(.SETTLE(1), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr),
        .load_stim(load_stim), .load_exp(load_exp), .run_len(run_len), .start(start),
        .dut_in(s_dut_in), .dut_out(s_dut_out), .busy(s_busy), .done(s_done), .pass(s_pass),
        .err_count(s_err_count), .first_fail_valid(s_ffv),
        .first_fail_idx(s_ffi), .res_valid(s_res_valid), .res_idx(s_res_idx),
        .res_data(s_res_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [3:0] a, input logic [19:0] s, input logic [9:0] e);
        load_en = 1'b1; load_addr = a; load_stim = s; load_exp = e;
        @(posedge clk); #1;
        load_en = 1'b0;
    endtask

    // Starts a run and records results; optionally injects load_en+start at cycle inj.
    task automatic run(input logic [4:0] len, input int inj);
        nres = 0; done_k = -1;
        run_len = len; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (k == inj) begin
                load_en = 1'b1; load_addr = 4'd1; load_stim = 20'h00020; load_exp = 10'h214;
                start = 1'b1;
            end else begin
                load_en = 1'b0; start = 1'b0;
            end
            if (res_valid) begin
                if (nres < 32) begin
                    got_idx[nres] = res_idx; got_data[nres] = res_data;
                end
                nres++;
            end
            if (done) begin
                done_k = k;
                break;
            end
            @(posedge clk); #1;
        end
        load_en = 1'b0; start = 1'b0;
    endtask

    task automatic check_multi(input string tag);
        chk({tag, "_nres"}, 64'(nres), 64'd4);
        chk({tag, "_idx0"}, 64'(got_idx[0]), 64'd0);
        chk({tag, "_idx3"}, 64'(got_idx[3]), 64'd3);
        chk({tag, "_data0"}, 64'(got_data[0]), 64'h210);
        chk({tag, "_data1"}, 64'(got_data[1]), 64'h218);
        chk({tag, "_data2"}, 64'(got_data[2]), 64'h214);
        chk({tag, "_data3"}, 64'(got_data[3]), 64'h21C);
        chk({tag, "_done_cycle"}, 64'(done_k), 64'd12);
        chk({tag, "_err"}, 64'(err_count), 64'd1);
        chk({tag, "_ffv"}, 64'(first_fail_valid), 64'd1);
        chk({tag, "_ffi"}, 64'(first_fail_idx), 64'd2);
        chk({tag, "_pass"}, 64'(pass), 64'd0);
        chk({tag, "_dut_in"}, 64'(dut_in), 64'h80020);
    endtask

    initial begin
        compared = 0; mismatched = 0;
        rst = 1'b1; load_en = 1'b0; load_addr = 4'd0; load_stim = 20'd0; load_exp = 10'd0;
        run_len = 5'd0; start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", {dut_in, busy, done, pass, err_count, first_fail_valid,
            first_fail_idx, res_valid, res_idx, res_data}, 64'd0);
        chk("reset_sat_outputs", {s_busy, s_done, s_pass, s_err_count, s_ffv}, 64'd0);
        rst = 1'b0;

        // Write with simultaneous start in IDLE: write lands, run does not begin.
        load_en = 1'b1; load_addr = 4'd0; load_stim = 20'h00000; load_exp = 10'h210;
        run_len = 5'd1; start = 1'b1;
        @(posedge clk); #1;
        load_en = 1'b0; start = 1'b0;
        chk("load_start_busy", 64'(busy), 64'd0);
        chk("load_start_done", 64'(done), 64'd0);

        run(5'd1, -1);
        chk("single_nres", 64'(nres), 64'd1);
        chk("single_data", 64'(got_data[0]), 64'h210);
        chk("single_done_cycle", 64'(done_k), 64'd3);
        chk("single_pass", 64'(pass), 64'd1);
        chk("single_err", 64'(err_count), 64'd0);
        chk("single_busy", 64'(busy), 64'd0);

        load(4'd1, 20'h80000, 10'h218);
        load(4'd2, 20'h00020, 10'h000);
        load(4'd3, 20'h80020, 10'h21C);
        run(5'd4, -1);
        check_multi("multi");

        run(5'd4, 5);
        check_multi("collide");
        run(5'd4, -1);
        check_multi("after_collide");

        // rst during SETTLE of vector 1 (four edges after the start edge).
        run_len = 5'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst_outputs", {dut_in, busy, done, pass, err_count, first_fail_valid,
            first_fail_idx, res_valid, res_idx, res_data}, 64'd0);
        rst = 1'b0;
        run(5'd4, -1);
        check_multi("replay");

        run(5'd0, -1);
        chk("len0_done_cycle", 64'(done_k), 64'd0);
        chk("len0_nres", 64'(nres), 64'd0);
        chk("len0_pass", 64'(pass), 64'd1);
        chk("len0_err", 64'(err_count), 64'd0);

        for (int i = 0; i < 16; i++) begin
            load(4'(i), 20'(i * 2), 10'h000);
        end
        run(5'd31, -1);
        chk("clamp_nres", 64'(nres), 64'd16);
        chk("clamp_done_cycle", 64'(done_k), 64'd48);
        chk("clamp_last_idx", 64'(got_idx[15]), 64'd15);
        chk("clamp_last_data", 64'(got_data[15]), 64'h210);
        chk("clamp_err", 64'(err_count), 64'd16);
        chk("sat_err", 64'(s_err_count), 64'd3);
        chk("sat_ffi", 64'(s_ffi), 64'd0);
        chk("sat_ffv", 64'(s_ffv), 64'd1);
        chk("sat_pass", 64'(s_pass), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/dut_vector_sequencer.md
Name: dut_vector_sequencer

Overview:
- Stimulus-and-check stage wrapped around the 20-in/10-out combinational dut.
- Holds a small vector table of {stimulus, expected} pairs and drives each stimulus onto the dut input.
- Waits a programmable settle time, samples the dut output and compares it against the expected value.
- Streams each captured result out for $writememb-style logging and reports the mismatch count plus the index of the first failing vector.

Parameters:
- IN_W, 20, stimulus width (dut input width)
- OUT_W, 10, result width (dut output width)
- DEPTH, 16, vector table entries
- ADDR_W, 4, table index width, clog2(DEPTH)
- SETTLE, 1, idle cycles between driving a stimulus and sampling the result (0 allowed)
- CNT_W, 8, error counter width

Ports:
- clk  input  1  single clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- load_en  input  1  table write strobe
- load_addr  input  ADDR_W  table write index
- load_stim  input  IN_W  stimulus to store
- load_exp  input  OUT_W  expected result to store
- run_len  input  ADDR_W+1  number of vectors to run; sampled on start
- start  input  1  begin run (single-cycle pulse)
- dut_in  output  IN_W  registered stimulus to the dut
- dut_out  input  OUT_W  dut result
- busy  output  1  run in progress
- done  output  1  run complete, held
- pass  output  1  done and err_count==0
- err_count  output  CNT_W  mismatches this run, saturating
- first_fail_valid  output  1  at least one mismatch this run
- first_fail_idx  output  ADDR_W  index of first mismatching vector
- res_valid  output  1  one-cycle pulse per captured result
- res_idx  output  ADDR_W  index of captured result
- res_data  output  OUT_W  captured dut_out

Behaviour:
- Decided interface rule: one clock; reset is synchronous and active-high.
- Reset: every output is 0 and the state is IDLE.
  - The table is not reset; it is retained across rst.
  - rst during a run aborts it immediately; no res_valid is issued for the aborted vector.
- Table write:
  - load_en is honoured in IDLE or DONE only: mem[load_addr] <= {load_stim, load_exp}.
  - load_en is ignored while busy.
  - If load_en and start arrive in the same cycle, the write is performed and start is ignored.
- States: IDLE, APPLY, SETTLE, CAPTURE, DONE.
- IDLE/DONE to APPLY on start (with load_en low):
  - Latch len = min(run_len, DEPTH); idx <= 0.
  - Clear err_count, first_fail_valid, first_fail_idx, done and pass.
  - busy <= 1.
- run_len == 0 on start: go straight to DONE the next cycle with pass=1, err_count=0 and no res_valid.
- APPLY: dut_in <= stim[idx].
  - Next state is SETTLE if SETTLE>0, else CAPTURE.
- SETTLE: count exactly SETTLE cycles, then go to CAPTURE.
- CAPTURE: sample dut_out, which reflects the dut_in registered in APPLY.
  - Pulse res_valid with res_idx=idx and res_data=dut_out.
  - On mismatch (dut_out != exp[idx]): err_count++, saturating at 2^CNT_W-1.
    - If first_fail_valid==0, set it and load first_fail_idx=idx.
  - If idx==len-1, go to DONE; otherwise idx++ and go to APPLY.
- Timing:
  - Per-vector latency is SETTLE+2 cycles.
  - done rises len*(SETTLE+2) cycles after the start cycle.
- DONE: busy=0, done=1, pass=(err_count==0); all held until the next start or rst.
  - dut_in holds the last stimulus.
- start while busy is ignored.
- Equality compare uses all OUT_W bits; there are no X/don't-care masks.

Test Plan:
- Single vector, dut connected: load addr0 = {20'h00000, 10'h210}, run_len=1, SETTLE=1, start.
  - Expect res_valid exactly once at cycle 3 with res_data=10'h210.
  - Expect done at cycle 3, pass=1, err_count=0.
- Multi-vector with one deliberate miss: entries
  - 0 = {20'h00000, 10'h210}
  - 1 = {20'h80000, 10'h218}
  - 2 = {20'h00020, 10'h000} (wrong; the dut gives 10'h214)
  - 3 = {20'h80020, 10'h21C}
  - With run_len=4, expect res_valid four times with res_idx 0..3.
  - Expect err_count=1, first_fail_valid=1, first_fail_idx=2, pass=0, done at cycle 12.
- run_len=0 then run_len=31 (beyond DEPTH):
  - run_len=0: done the next cycle with pass=1 and no res_valid.
  - run_len=31: clamps to 16, giving 16 res_valid pulses and done at cycle 48.
- Saturation: CNT_W=2 with 16 all-wrong entries -> err_count sticks at 3 and first_fail_idx=0.
- Control collisions, each of the following must have no effect on the run (dut_in, res_data and err_count unchanged):
  - load_en pulsed mid-run: table unchanged.
  - start pulsed mid-run: ignored.
  - load_en with start in IDLE: write happens, busy stays 0.
- Reset mid-run: assert rst during SETTLE of vector 1.
  - Next cycle all outputs are 0 and the state is IDLE.
  - A subsequent start replays from idx 0 with the table intact.
